pipe_stage_buf: RTL

// - Parametrised pipeline-stage register for inter-stage latches (IF/ID, ID/EX, ...) with a DEPTH-entry skid queue.
// - Replaces hand-written per-stage latches with valid/ready handshake, stall absorption and synchronous flush.
// - Sits between two pipeline stages. Producer drives in_*, consumer drives out_ready.
// - Lets the fetch stage keep fetching for DEPTH cycles while decode stalls.

---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_buf_if.sv | 29 ++
 rtl/pipe_wrap_ctr.sv | 36 +++
 rtl/pipe_stage_buf.sv | 99 +++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide types shared by the pipeline stages.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pipe_pkg.sv
// Shared helpers and payload layouts for the inter-stage pipeline buffers.
package pipe_pkg;

    import cpu_types_pkg::*;

    // Pointer width for a DEPTH-entry queue; a single-entry queue still gets one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // IF/ID latch contents: fetched instruction plus the sequential PC.
    typedef struct packed {
        word_t imemload;
        word_t pcp4;
    } ifid_payload_t;

    localparam int IFID_W = $bits(ifid_payload_t);

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between a producer stage, a pipe_stage_buf and a consumer stage.
// The slave modport is the buffer's view; master is the surrounding stages' view.
interface pipe_stage_buf_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_wrap_ctr.sv
// Enable-driven modulo counter 0..MAX with synchronous clear; used as a queue pointer.
module pipe_wrap_ctr #(
    parameter int MAX = 1,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] value_o
);

    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Advance by one when enabled, wrapping from MAX back to zero.
    always_comb begin
        value_d = value_q;
        if (en_i) begin
            value_d = (value_q == LAST) ? '0 : value_q + 1'b1;
        end
    end

    // Clear wins over advancing so reset/flush always land on slot zero.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a DEPTH-entry skid queue, valid/ready handshake and flush.
// Outputs are purely registered: nothing pushed this cycle is visible until the next one,
// and in_ready depends only on occupancy so there is no path from out_ready to in_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 2,
    parameter int ZERO_ON_EMPTY = 1
) (
    input  logic CLK,
    input  logic RST,
    pipe_stage_buf_if.slave bus
);

    localparam int               PTR_W = ptr_w(DEPTH);
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             clear;
    logic             push;
    logic             pop;
    logic             in_ready_w;
    logic             out_valid_w;
    logic [WIDTH-1:0] out_data_w;

    assign clear       = RST | bus.flush;
    assign in_ready_w  = (count_q != FULL);
    assign out_valid_w = (count_q != '0);
    assign push        = bus.in_valid & in_ready_w & ~bus.flush;
    assign pop         = out_valid_w & bus.out_ready & ~bus.flush;

    pipe_wrap_ctr #(
        .MAX (DEPTH - 1),
        .W   (PTR_W)
    ) u_wr_ctr (
        .clk_i   (CLK),
        .clear_i (clear),
        .en_i    (push),
        .value_o (wr_ptr)
    );

    pipe_wrap_ctr #(
        .MAX (DEPTH - 1),
        .W   (PTR_W)
    ) u_rd_ctr (
        .clk_i   (CLK),
        .clear_i (clear),
        .en_i    (pop),
        .value_o (rd_ptr)
    );

    // Storage is not reset; a write is suppressed during reset so reset leaves it untouched.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr] <= bus.in_data;
        end
    end

    // Occupancy moves only when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Reset and flush both empty the queue at the edge.
    always_ff @(posedge CLK) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Head entry, optionally replaced by zero (a nop bubble) when the queue is empty.
    always_comb begin
        out_data_w = mem_q[rd_ptr];
        if (!out_valid_w && (ZERO_ON_EMPTY != 0)) begin
            out_data_w = '0;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.count     = count_q;

    countBound: assert property (@(posedge CLK) disable iff (RST) count_q <= FULL);

endmodule
